// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the Famicom CPU-bus sequencer.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  localparam logic PORT_HOST   = 1'b0;
  localparam logic PORT_ENGINE = 1'b1;

  // Bus levels presented whenever no access is in flight.
  localparam logic        IDLE_RW     = 1'b1;
  localparam logic        IDLE_ROMSEL = 1'b1;
  localparam logic        IDLE_OE     = 1'b0;
  localparam logic [15:0] RESET_ADDR  = 16'h0000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the grant decision is only committed
// (and last_grant updated) when sample is high.
module rr_arbiter2
  import cpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic       grant_port
);

  logic last_grant;

  always_comb begin
    grant_valid = sample && (req != 2'b00);
    if (req == 2'b11) grant_port = ~last_grant;
    else              grant_port = req[1];
  end

  // Reset favours the host on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_grant <= PORT_ENGINE;
    else if (grant_valid) last_grant <= grant_port;
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Generates M2 from master_clock and runs one CPU-bus access per M2 period
// for the host (port 0) and burst/verify engine (port 1).
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int M2_LOW_CYCLES  = 5,
  parameter int M2_HIGH_CYCLES = 7
) (
  input  logic        master_clock,
  input  logic        reset,
  input  logic        m2_enable,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  input  logic [7:0]  cpu_data_in,
  output logic        m2,
  output logic [15:0] cpu_addr,
  output logic        cpu_rw,
  output logic        romsel,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int PERIOD = M2_LOW_CYCLES + M2_HIGH_CYCLES;
  localparam int CW     = $clog2(PERIOD);

  localparam logic [CW-1:0] CNT_LAST       = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST   = CW'(PERIOD - 2);
  localparam logic [CW-1:0] CNT_LOW_LAST   = CW'(M2_LOW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HIGH_FIRST = CW'(M2_LOW_CYCLES);

  logic [CW-1:0] count, count_next;
  logic          at_start, advancing, sample;
  seq_state_e    state, state_next;
  logic          granted;

  logic          grant_valid, grant_port;
  logic [15:0]   win_addr;
  logic          win_we;
  logic [7:0]    win_wdata;

  logic [15:0]   addr_q;
  logic          we_q;
  logic [7:0]    wdata_q;
  logic          port_q;

  // Phase counter: parks at 0 while M2 is disabled.
  assign at_start  = (count == '0);
  assign advancing = !at_start || m2_enable;
  // Gating with reset keeps the combinational count-0 bus view at idle levels.
  assign sample    = at_start && m2_enable && !reset;

  always_comb begin
    count_next = count;
    if (advancing) count_next = (count == CNT_LAST) ? '0 : count + CW'(1);
  end

  assign m2 = (count >= CNT_HIGH_FIRST);

  rr_arbiter2 u_arb (
    .clk         (master_clock),
    .rst         (reset),
    .sample      (sample),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    win_addr  = (grant_port == PORT_HOST) ? addr0  : addr1;
    win_wdata = (grant_port == PORT_HOST) ? wdata0 : wdata1;
    win_we    = we[grant_port];
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_next = ST_SETUP;
      ST_SETUP:  if (count == CNT_LOW_LAST) state_next = ST_ACCESS;
      ST_ACCESS: if (count == CNT_PRE_LAST) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      state   <= ST_IDLE;
      addr_q  <= RESET_ADDR;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      port_q  <= PORT_HOST;
      rdata   <= 8'h00;
    end else begin
      count <= count_next;
      state <= state_next;
      if (grant_valid) begin
        addr_q  <= win_addr;
        we_q    <= win_we;
        wdata_q <= win_wdata;
        port_q  <= grant_port;
      end
      if (state == ST_ACCESS && state_next == ST_FINISH && !we_q) rdata <= cpu_data_in;
    end
  end

  assign granted = (state != ST_IDLE);

  // During count 0 the winner is shown straight from its inputs, so address
  // and direction are valid for the whole period; latched copies take over.
  always_comb begin
    cpu_addr    = addr_q;
    cpu_rw      = IDLE_RW;
    cpu_data_oe = IDLE_OE;
    busy        = granted;
    if (grant_valid) begin
      cpu_addr = win_addr;
      cpu_rw   = !win_we;
      busy     = 1'b1;
    end else if (granted) begin
      cpu_rw      = !we_q;
      cpu_data_oe = we_q;
    end
    romsel = granted ? !(m2 && addr_q[15]) : IDLE_ROMSEL;
    ack    = 2'b00;
    if (state == ST_FINISH) ack[port_q] = 1'b1;
  end

  assign cpu_data_out = wdata_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomised bench for cpu_bus_sequencer with a period-level reference model
// and an ack-driven scoreboard.
module tb_cpu_bus_sequencer;

  localparam int L  = 5;
  localparam int H  = 7;
  localparam int P  = L + H;
  localparam int EW = 10;

  logic        clk;
  logic        rst;
  logic        m2_enable;
  logic [1:0]  req, we;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic [7:0]  cpu_data_in;
  logic        m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw, romsel;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe, busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  cpu_bus_sequencer #(.M2_LOW_CYCLES(L), .M2_HIGH_CYCLES(H)) dut (
    .master_clock (clk),
    .reset        (rst),
    .m2_enable    (m2_enable),
    .req          (req),
    .we           (we),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack          (ack),
    .rdata        (rdata),
    .cpu_data_in  (cpu_data_in),
    .m2           (m2),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .romsel       (romsel),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          mcount;
  logic        m_last, m_busy, m_port, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wd, m_rdata;
  logic [1:0]  pk_now;

  // Round robin: a lone requester wins; on a tie the one not served last wins.
  function automatic logic [1:0] pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return {1'b1, ~last};
    if (r == 2'b01) return 2'b10;
    if (r == 2'b10) return 2'b11;
    return 2'b00;
  endfunction

  always_comb pk_now = pick(req, m_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcount  <= 0;
      m_last  <= 1'b1;
      m_busy  <= 1'b0;
      m_port  <= 1'b0;
      m_we    <= 1'b0;
      m_wd    <= 8'h00;
      m_rdata <= 8'h00;
      m_addr  <= 16'h0000;
    end else begin
      if (mcount == 0 && m2_enable && pk_now[1]) begin
        m_busy <= 1'b1;
        m_port <= pk_now[0];
        m_we   <= we[pk_now[0]];
        m_addr <= pk_now[0] ? addr1 : addr0;
        m_wd   <= pk_now[0] ? wdata1 : wdata0;
        m_last <= pk_now[0];
      end
      if (m_busy && mcount == P - 2) begin
        if (!m_we) m_rdata <= cpu_data_in;
        exp_q.push_back({(m_port ? 2'b10 : 2'b01), (m_we ? m_rdata : cpu_data_in)});
      end
      if (m_busy && mcount == P - 1) m_busy <= 1'b0;
      if (mcount != 0 || m2_enable) mcount <= (mcount + 1) % P;
    end
  end

  logic        e_m2, e_rw, e_oe, e_romsel, e_busy;
  logic [15:0] e_addr;
  logic [1:0]  e_ack;

  always_comb begin
    e_m2     = (mcount >= L);
    e_addr   = m_addr;
    e_rw     = 1'b1;
    e_oe     = 1'b0;
    e_romsel = 1'b1;
    e_busy   = 1'b0;
    e_ack    = 2'b00;
    if (mcount == 0 && m2_enable && pk_now[1]) begin
      e_addr = pk_now[0] ? addr1 : addr0;
      e_rw   = !we[pk_now[0]];
      e_busy = 1'b1;
    end else if (m_busy) begin
      e_rw     = !m_we;
      e_oe     = m_we;
      e_busy   = 1'b1;
      e_romsel = !(e_m2 && m_addr[15]);
      if (mcount == P - 1) e_ack = m_port ? 2'b10 : 2'b01;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [1:0] ack_last;

  always @(negedge clk) begin
    ack_last <= ack;
    if (!rst) begin
      chk("m2", m2, e_m2);
      chk("cpu_addr", cpu_addr, e_addr);
      chk("cpu_rw", cpu_rw, e_rw);
      chk("cpu_data_oe", cpu_data_oe, e_oe);
      chk("romsel", romsel, e_romsel);
      chk("busy", busy, e_busy);
      chk("ack", ack, e_ack);
      chk("rdata_hold", rdata, m_rdata);
      if (e_oe) chk("cpu_data_out", cpu_data_out, m_wd);
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) chk("ack_unexpected", ack, 0);
        else begin
          chk("sb_ack", ack, exp_q[0][9:8]);
          chk("sb_rdata", rdata, exp_q[0][7:0]);
          exp_q.delete(0);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic       data_rand;
  logic [7:0] data_fixed;

  initial begin
    cpu_data_in = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cpu_data_in = data_rand ? 8'($urandom) : data_fixed;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int p, input logic w, input logic [15:0] a, input logic [7:0] d);
    req[p] = 1'b1;
    we[p]  = w;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
  endtask

  task automatic rand_cmd(input int p);
    set_cmd(p, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
  endtask

  task automatic wait_count(input int c);
    int n = 0;
    while (mcount != c && n < 100) begin tick(); n++; end
    if (mcount != c) chk("wait_count", mcount, c);
  endtask

  task automatic wait_ack(input int p, output logic got);
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      tick();
      if (ack_last[p]) got = 1'b1;
    end
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (m2_enable ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 19) == 0))
        m2_enable = ~m2_enable;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && ack_last[p]) begin
          if ($urandom_range(0, 1) == 1) rand_cmd(p);
          else req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(0, 3) == 0) begin
          rand_cmd(p);
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       got;
    logic [1:0] seen;
    int         n;

    rst = 1'b1; m2_enable = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0;
    data_rand = 1'b1; data_fixed = 8'h00;
    repeat (3) tick();
    chk("rst_m2", m2, 0);
    chk("rst_cpu_addr", cpu_addr, 0);
    chk("rst_cpu_rw", cpu_rw, 1);
    chk("rst_romsel", romsel, 1);
    chk("rst_data_out", cpu_data_out, 0);
    chk("rst_oe", cpu_data_oe, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0; m2_enable = 1'b1;

    // Idle M2 periods.
    repeat (24) tick();

    // Port 0 reads ROM space with the bus returning 0xA5.
    data_rand = 1'b0; data_fixed = 8'hA5;
    wait_count(0);
    set_cmd(0, 1'b0, 16'h8000, 8'h00);
    wait_ack(0, got);
    chk("rd_ack_seen", got, 1);
    chk("rd_rdata", rdata, 8'hA5);
    req[0] = 1'b0;
    data_rand = 1'b1;

    // Port 1 writes 0x3C to 0x5000.
    set_cmd(1, 1'b1, 16'h5000, 8'h3C);
    wait_ack(1, got);
    chk("wr_ack_seen", got, 1);
    req[1] = 1'b0;

    // Both ports continuously requesting straight out of reset.
    rst = 1'b1;
    tick();
    set_cmd(0, 1'b0, 16'h9000, 8'h00);
    set_cmd(1, 1'b1, 16'h6000, 8'h11);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin tick(); n++; end while (ack_last == 2'b00 && n < 40);
      chk("alt_port", ack_last, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i > 0) chk("alt_gap", n, P);
      rand_cmd(ack_last[1] ? 1 : 0);
    end
    req = 2'b00;

    // Granted request withdrawn early still completes.
    wait_count(0);
    set_cmd(0, 1'b0, 16'h9234, 8'h00);
    wait_count(3);
    req[0] = 1'b0;
    wait_ack(0, got);
    chk("abort_ack_seen", got, 1);

    // Request raised after count 0 and withdrawn before the next is never seen.
    wait_count(2);
    set_cmd(1, 1'b1, 16'h4444, 8'h44);
    wait_count(6);
    req[1] = 1'b0;
    seen = 2'b00;
    repeat (30) begin tick(); seen |= ack_last; end
    chk("ungranted_no_ack", seen, 0);

    // M2 disabled mid-access: access finishes, then the bus parks.
    wait_count(11);
    set_cmd(0, 1'b1, 16'hC000, 8'h5A);
    wait_count(3);
    m2_enable = 1'b0;
    wait_ack(0, got);
    chk("dis_ack_seen", got, 1);
    req[0] = 1'b0;
    set_cmd(1, 1'b0, 16'hE000, 8'h00);
    seen = 2'b00;
    repeat (36) begin tick(); seen |= ack_last; end
    chk("dis_no_ack", seen, 0);
    chk("dis_m2_low", m2, 0);
    chk("dis_busy", busy, 0);
    m2_enable = 1'b1;
    wait_ack(1, got);
    chk("reen_ack_seen", got, 1);
    req[1] = 1'b0;

    // Randomised traffic with occasional M2 stops.
    run_random(3000);
    req = 2'b00;
    m2_enable = 1'b1;
    repeat (40) tick();

    // Reset in the middle of a port-0 write.
    wait_count(11);
    set_cmd(0, 1'b1, 16'h8123, 8'h77);
    wait_count(8);
    rst = 1'b1;
    #1;
    chk("mrst_oe", cpu_data_oe, 0);
    chk("mrst_rw", cpu_rw, 1);
    chk("mrst_m2", m2, 0);
    chk("mrst_ack", ack, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_romsel", romsel, 1);
    chk("mrst_data_out", cpu_data_out, 0);
    req[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    seen = 2'b00;
    repeat (30) begin tick(); seen |= ack_last; end
    chk("mrst_no_ack", seen, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
